// File: rtl/xor_checksum_acc.sv
// xor_checksum_acc: XOR-reduces the CHANNELS lanes of each accepted beat and
// XOR-accumulates beats into a frame checksum. A closed frame (in_last or
// MAX_BEATS reached) is presented through a valid/ready result register.
module xor_checksum_acc #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 2,
    parameter int MAX_BEATS = 4,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_checksum,
    output logic                      out_parity,
    output logic [CW-1:0]             out_beats,
    output logic                      out_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] beat_x;
    logic [WIDTH-1:0] sum;
    logic             accept;
    logic             close;

    logic             out_valid_next;
    logic [WIDTH-1:0] out_checksum_next;
    logic             out_parity_next;
    logic [CW-1:0]    out_beats_next;
    logic             out_err_next;

    // The result register can take a new value when empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + CW'(1);
    assign close    = accept && (in_last || (cnt_inc == CW'(MAX_BEATS)));

    // Lane reduction of the incoming beat.
    always_comb begin
        beat_x = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            beat_x = beat_x ^ in_data[k*WIDTH +: WIDTH];
        end
    end

    // Running checksum including this beat; an idle accumulator counts as zero.
    assign sum = ((state == IDLE) ? '0 : acc) ^ beat_x;

    // Next-state, accumulator and result-register update.
    always_comb begin
        state_next        = state;
        acc_next          = acc;
        cnt_next          = cnt;
        out_valid_next    = out_valid;
        out_checksum_next = out_checksum;
        out_parity_next   = out_parity;
        out_beats_next    = out_beats;
        out_err_next      = out_err;

        if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            if (close) begin
                out_valid_next    = 1'b1;
                out_checksum_next = sum;
                out_parity_next   = ^sum;
                out_beats_next    = cnt_inc;
                out_err_next      = !in_last;
                acc_next          = '0;
                cnt_next          = '0;
                state_next        = IDLE;
            end else begin
                acc_next   = sum;
                cnt_next   = cnt_inc;
                state_next = ACCUM;
            end
        end
    end

    // State, accumulator and result registers; reset drops any partial frame
    // and any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_checksum <= '0;
            out_parity   <= 1'b0;
            out_beats    <= '0;
            out_err      <= 1'b0;
        end else begin
            state        <= state_next;
            acc          <= acc_next;
            cnt          <= cnt_next;
            out_valid    <= out_valid_next;
            out_checksum <= out_checksum_next;
            out_parity   <= out_parity_next;
            out_beats    <= out_beats_next;
            out_err      <= out_err_next;
        end
    end

endmodule

// File: tb/tb_xor_checksum_acc.sv
// Bench for xor_checksum_acc: directed test-plan steps followed by random
// traffic, all compared against a frame-level reference model.
module tb_xor_checksum_acc;

    localparam int WIDTH     = 8;
    localparam int CHANNELS  = 2;
    localparam int MAX_BEATS = 4;
    localparam int CW        = $clog2(MAX_BEATS + 1);
    localparam int DW        = CHANNELS * WIDTH;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [WIDTH-1:0] out_checksum;
    logic          out_parity;
    logic [CW-1:0] out_beats;
    logic          out_err;

    int total = 0;
    int bad   = 0;

    // Reference model: the beats of the open frame plus the held result.
    logic [WIDTH-1:0] frame[$];
    logic             m_valid;
    logic [WIDTH-1:0] m_cs;
    logic             m_par;
    int               m_beats;
    logic             m_err;

    xor_checksum_acc #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_checksum(out_checksum), .out_parity(out_parity),
        .out_beats(out_beats), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] lanes_xor(input logic [DW-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) r = r ^ d[k*WIDTH +: WIDTH];
        return r;
    endfunction

    task automatic model_clear();
        frame.delete();
        m_valid = 1'b0;
        m_cs    = '0;
        m_par   = 1'b0;
        m_beats = 0;
        m_err   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},  32'(out_valid),    32'(m_valid));
        check({tag, ".cs"},     32'(out_checksum), 32'(m_cs));
        check({tag, ".par"},    32'(out_parity),   32'(m_par));
        check({tag, ".beats"},  32'(out_beats),    32'(m_beats));
        check({tag, ".err"},    32'(out_err),      32'(m_err));
    endtask

    // One clock with the currently driven inputs; model follows the frame rules.
    task automatic cycle(input string tag);
        logic acc_ok;
        logic [WIDTH-1:0] cs;
        #2;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
        acc_ok = in_valid && (!m_valid || out_ready);
        @(posedge clk);
        #1;
        if (m_valid && out_ready) m_valid = 1'b0;
        if (acc_ok) begin
            frame.push_back(lanes_xor(in_data));
            if (in_last || frame.size() == MAX_BEATS) begin
                cs = '0;
                foreach (frame[i]) cs = cs ^ frame[i];
                m_cs    = cs;
                m_par   = ^cs;
                m_beats = frame.size();
                m_err   = !in_last;
                m_valid = 1'b1;
                frame.delete();
            end
        end
        check_outputs(tag);
    endtask

    task automatic beat(input string tag, input logic [DW-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        cycle(tag);
    endtask

    task automatic idle(input string tag, input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // Asserts rst between clock edges and checks the asynchronous clear.
    task automatic apply_reset(input string tag);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs({tag, ".async"});
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check_outputs({tag, ".post"});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_clear();
        #1;
        check_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset asserted mid-cycle.
        apply_reset("reset");

        // Single-beat frame.
        beat("single", 16'hA50F, 1'b1);
        check("single.cs_const", 32'(out_checksum), 32'h0000_00AA);
        check("single.beats_const", 32'(out_beats), 32'd1);

        // Multi-beat frame.
        beat("multi0", 16'h0102, 1'b0);
        beat("multi1", 16'h0408, 1'b0);
        beat("multi2", 16'h1020, 1'b1);
        check("multi.cs_const", 32'(out_checksum), 32'h0000_003F);
        check("multi.beats_const", 32'(out_beats), 32'd3);

        // Backpressure: result held, next beat stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hFF00;
        in_last   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            check("bp.in_ready_low", 32'(in_ready), 32'd0);
            check("bp.cs_stable", 32'(out_checksum), 32'h0000_003F);
        end
        out_ready = 1'b1;
        cycle("bp_release");
        check("bp.cs_const", 32'(out_checksum), 32'h0000_00FF);
        check("bp.valid_const", 32'(out_valid), 32'd1);
        idle("drain", 1);

        // Forced close at MAX_BEATS, then a normal single-beat frame.
        for (int i = 0; i < 4; i++) beat("force", 16'h0100, 1'b0);
        check("force.err_const", 32'(out_err), 32'd1);
        check("force.beats_const", 32'(out_beats), 32'd4);
        beat("after_force", 16'h0300, 1'b1);
        check("after_force.cs_const", 32'(out_checksum), 32'h0000_0003);
        check("after_force.err_const", 32'(out_err), 32'd0);
        idle("drain", 1);

        // Reset mid-frame discards the partial frame.
        beat("mid0", 16'hF000, 1'b0);
        beat("mid1", 16'h0F00, 1'b0);
        apply_reset("mid_reset");
        beat("mid_after", 16'h1122, 1'b1);
        check("mid.cs_const", 32'(out_checksum), 32'h0000_0033);
        check("mid.beats_const", 32'(out_beats), 32'd1);

        // Random traffic with random backpressure and one reset with a result pending.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) apply_reset("rand_reset");
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom());
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end
        out_ready = 1'b1;
        idle("final", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
